// File: rtl/rst_pkg.sv
// Shared types for the SoC reset sequencer.
// Holds the sequencer state enum, reset-cause codes and counter sizing.
package rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    REL_SYS   = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;
  localparam logic [1:0] CAUSE_WDT  = 2'd3;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Width of the shared sequencer counter.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-release reset synchronizer.
// Ports: clk, i_rst_n (async active-low in), o_rst_n (synced release out).
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_n = r_sync[STAGES-1];

endmodule

// File: rtl/sys_rst_gen.sv
// SoC reset sequencer: waits for stable PLL lock, releases bus reset,
// then CPU reset; re-enters reset on lock loss, soft request or watchdog.
// Ports: clk, rst_n (board reset), pll_lock (async), soft_rst_req,
// wdt_expire (clk domain pulses); sys_rst_n, cpu_rst_n, rst_done,
// rst_cause (0 ext, 1 lock loss, 2 soft, 3 watchdog).
module sys_rst_gen
  import rst_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CPU_DELAY          = 16,
  parameter int SOFT_HOLD          = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  input  logic       wdt_expire,
  output logic       sys_rst_n,
  output logic       cpu_rst_n,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  localparam int CW =
    cnt_width(LOCK_STABLE_CYCLES, CPU_DELAY, SOFT_HOLD);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DELAY - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SOFT_HOLD - 1);

  logic w_arst_n;
  logic w_lock_s;

  logic [SYNC_STAGES-1:0] r_lock_sync;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_cause;
  logic [1:0]    w_cause_nxt;
  logic          r_sys_rst_n;
  logic          w_sys_nxt;
  logic          r_cpu_rst_n;
  logic          w_cpu_nxt;
  logic          r_done;
  logic          w_done_nxt;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk     (clk),
    .i_rst_n (rst_n),
    .o_rst_n (w_arst_n)
  );

  // Plain lock synchronizer; cleared with the rest of the block.
  always_ff @(posedge clk or negedge w_arst_n) begin
    if (!w_arst_n) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge w_arst_n) begin
    if (!w_arst_n) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_cause     <= CAUSE_EXT;
      r_sys_rst_n <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cause     <= w_cause_nxt;
      r_sys_rst_n <= w_sys_nxt;
      r_cpu_rst_n <= w_cpu_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_cause_nxt = r_cause;

    unique case (r_state)
      WAIT_LOCK: begin
        if (!w_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = REL_SYS;
        end
      end
      REL_SYS: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cause_nxt = CAUSE_LOCK;
        end else if (r_cnt == CPU_LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cause_nxt = CAUSE_LOCK;
        end else if (wdt_expire) begin
          w_state_nxt = HOLD;
          w_cause_nxt = CAUSE_WDT;
        end else if (soft_rst_req) begin
          w_state_nxt = HOLD;
          w_cause_nxt = CAUSE_SOFT;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cause_nxt = CAUSE_LOCK;
        end else if (r_cnt == HOLD_LAST) begin
          // Lock is already proven stable; skip the lock count.
          w_state_nxt = REL_SYS;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they register
    // on the same edge as the transition.
    w_sys_nxt  = (w_state_nxt == REL_SYS) || (w_state_nxt == RUN);
    w_cpu_nxt  = (w_state_nxt == RUN);
    w_done_nxt = (w_state_nxt == RUN);
  end

  assign sys_rst_n = r_sys_rst_n;
  assign cpu_rst_n = r_cpu_rst_n;
  assign rst_done  = r_done;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_sys_rst_gen.sv
// Self-checking bench for sys_rst_gen: directed scenarios then random
// lock glitches, requests and board resets against a timestamp model.
module tb_sys_rst_gen;

  localparam int LSC = 8;
  localparam int CPD = 4;
  localparam int SH  = 6;
  localparam int INF = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       wdt_expire;
  logic       sys_rst_n;
  logic       cpu_rst_n;
  logic       rst_done;
  logic [1:0] rst_cause;

  int n_checks = 0;
  int n_errors = 0;
  int n = 0;

  bit         m_wait;
  int         m_sys_rel;
  int         m_cpu_rel;
  int         m_stable;
  logic [1:0] m_cause;
  int         m_rcnt;
  bit         m_p1;
  bit         m_p2;

  sys_rst_gen #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (LSC),
    .CPU_DELAY          (CPD),
    .SOFT_HOLD          (SH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .soft_rst_req (soft_rst_req),
    .wdt_expire   (wdt_expire),
    .sys_rst_n    (sys_rst_n),
    .cpu_rst_n    (cpu_rst_n),
    .rst_done     (rst_done),
    .rst_cause    (rst_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait    = 1'b1;
    m_sys_rel = INF;
    m_cpu_rel = INF;
    m_stable  = -1;
    m_cause   = 2'd0;
    m_rcnt    = 0;
    m_p1      = 1'b0;
    m_p2      = 1'b0;
  endtask

  // Release times are edge numbers; outputs are high from that edge on.
  task automatic model_edge(
    input bit r,
    input bit pl,
    input bit sf,
    input bit wd
  );
    bit act;
    bit ls;
    if (!r) begin
      model_reset();
      return;
    end
    act = (m_rcnt >= 2);
    if (m_rcnt < 2) m_rcnt++;
    if (!act) return;
    ls   = m_p2;
    m_p2 = m_p1;
    m_p1 = pl;
    if (!m_wait && !ls) begin
      m_wait    = 1'b1;
      m_sys_rel = INF;
      m_cpu_rel = INF;
      m_stable  = -1;
      m_cause   = 2'd1;
    end else if (!m_wait && m_cpu_rel <= n - 1 && (sf || wd)) begin
      m_cause   = wd ? 2'd3 : 2'd2;
      m_sys_rel = n + SH;
      m_cpu_rel = n + SH + CPD;
    end else if (m_wait) begin
      if (ls) begin
        if (m_stable < 0) m_stable = n - 1;
        if (n - m_stable == LSC) begin
          m_wait    = 1'b0;
          m_stable  = -1;
          m_sys_rel = n;
          m_cpu_rel = n + CPD;
        end
      end else begin
        m_stable = -1;
      end
    end
  endtask

  task automatic check_model();
    chk($sformatf("sys@%0d", n), sys_rst_n, n >= m_sys_rel);
    chk($sformatf("cpu@%0d", n), cpu_rst_n, n >= m_cpu_rel);
    chk($sformatf("done@%0d", n), rst_done, n >= m_cpu_rel);
    chk($sformatf("cause@%0d", n), rst_cause, m_cause);
  endtask

  task automatic tick();
    logic r;
    logic pl;
    logic sf;
    logic wd;
    r  = rst_n;
    pl = pll_lock;
    sf = soft_rst_req;
    wd = wdt_expire;
    @(posedge clk);
    n++;
    model_edge(r, pl, sf, wd);
    #1;
    check_model();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic async_rst();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sys", sys_rst_n, 0);
    chk("arst_cpu", cpu_rst_n, 0);
    chk("arst_done", rst_done, 0);
    chk("arst_cause", rst_cause, 0);
    model_reset();
  endtask

  initial begin
    int gl;
    rst_n        = 1'b0;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    wdt_expire   = 1'b0;
    model_reset();
    ticks(3);
    chk("rst_sys", sys_rst_n, 0);
    chk("rst_cpu", cpu_rst_n, 0);
    chk("rst_done", rst_done, 0);
    chk("rst_cause", rst_cause, 0);

    // Power-up
    rst_n = 1'b1;
    ticks(4);
    pll_lock = 1'b1;
    ticks(9);
    chk("pwr_sys_early", sys_rst_n, 0);
    tick();
    chk("pwr_sys_rise", sys_rst_n, 1);
    chk("pwr_cpu_low", cpu_rst_n, 0);
    ticks(3);
    chk("pwr_cpu_early", cpu_rst_n, 0);
    tick();
    chk("pwr_cpu_rise", cpu_rst_n, 1);
    chk("pwr_done", rst_done, 1);
    chk("pwr_cause", rst_cause, 0);

    // Lock loss in RUN, then glitch during the lock count
    pll_lock = 1'b0;
    ticks(2);
    chk("loss_cause_early", rst_cause, 0);
    tick();
    chk("loss_cause", rst_cause, 1);
    chk("loss_sys", sys_rst_n, 0);
    pll_lock = 1'b1;
    ticks(5);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    ticks(9);
    chk("glitch_sys_early", sys_rst_n, 0);
    tick();
    chk("glitch_sys_rise", sys_rst_n, 1);
    ticks(4);
    chk("glitch_cpu", cpu_rst_n, 1);

    // Soft reset in RUN
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("soft_sys_low", sys_rst_n, 0);
    chk("soft_cpu_low", cpu_rst_n, 0);
    chk("soft_cause", rst_cause, 2);
    ticks(5);
    chk("soft_sys_early", sys_rst_n, 0);
    tick();
    chk("soft_sys_rise", sys_rst_n, 1);
    ticks(3);
    chk("soft_cpu_early", cpu_rst_n, 0);
    tick();
    chk("soft_cpu_rise", cpu_rst_n, 1);

    // Simultaneous soft + watchdog, then both in REL_SYS
    soft_rst_req = 1'b1;
    wdt_expire   = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    wdt_expire   = 1'b0;
    chk("wdt_cause", rst_cause, 3);
    chk("wdt_sys_low", sys_rst_n, 0);
    ticks(6);
    chk("wdt_sys_rise", sys_rst_n, 1);
    soft_rst_req = 1'b1;
    wdt_expire   = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    wdt_expire   = 1'b0;
    chk("relsys_ign_sys", sys_rst_n, 1);
    chk("relsys_ign_cause", rst_cause, 3);
    ticks(2);
    chk("wdt_cpu_early", cpu_rst_n, 0);
    tick();
    chk("wdt_cpu_rise", cpu_rst_n, 1);

    // Lock loss during HOLD
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    ticks(2);
    pll_lock = 1'b0;
    ticks(2);
    chk("hold_cause_early", rst_cause, 2);
    tick();
    chk("hold_loss_cause", rst_cause, 1);
    ticks(3);
    chk("hold_loss_sys", sys_rst_n, 0);
    pll_lock = 1'b1;
    ticks(9);
    chk("hold_relock_early", sys_rst_n, 0);
    tick();
    chk("hold_relock_rise", sys_rst_n, 1);

    // Board reset mid-REL_SYS
    tick();
    async_rst();
    ticks(2);
    rst_n = 1'b1;
    ticks(11);
    chk("rerun_sys_early", sys_rst_n, 0);
    tick();
    chk("rerun_sys_rise", sys_rst_n, 1);
    chk("rerun_cause", rst_cause, 0);
    ticks(4);
    chk("rerun_done", rst_done, 1);

    // Random phase
    gl = 0;
    for (int i = 0; i < 800; i++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        async_rst();
      end
      if (gl > 0) begin
        pll_lock = 1'b0;
        gl--;
      end else if ($urandom_range(0, 59) == 0) begin
        gl = int'($urandom_range(0, 2));
        pll_lock = 1'b0;
      end else begin
        pll_lock = 1'b1;
      end
      soft_rst_req = ($urandom_range(0, 24) == 0);
      wdt_expire   = ($urandom_range(0, 34) == 0);
      tick();
    end
    soft_rst_req = 1'b0;
    wdt_expire   = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
